// File: rtl/router_pkg.sv
// Width helpers shared by the buffered router top and its per-channel FIFOs.
package router_pkg;

   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Single-channel circular FIFO with count-based full/empty; pointers wrap at
// p_depth-1 so non-power-of-two depths work.
module router_fifo import router_pkg::*; #(
   parameter int p_nbits = 29,
   parameter int p_depth = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enq_val,
   input  logic [p_nbits-1:0]           enq_msg,
   output logic                         full,
   input  logic                         deq_rdy,
   output logic                         deq_val,
   output logic [p_nbits-1:0]           deq_msg,
   output logic [cnt_w(p_depth)-1:0]    count
);

   localparam int CW = cnt_w(p_depth);
   localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam logic [PW-1:0] LAST = PW'(p_depth - 1);

   logic [p_nbits-1:0] mem [p_depth];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic               enq;
   logic               deq;

   assign full    = (count == CW'(p_depth));
   assign deq_val = (count != '0);
   assign enq     = enq_val && !full;
   assign deq     = deq_rdy && deq_val;
   assign deq_msg = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (deq) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (enq && !deq)
            count <= count + 1'b1;
         else if (deq && !enq)
            count <= count - 1'b1;
      end
   end

   // Payload storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= enq_msg;
   end

endmodule

// File: rtl/buffered_router.sv
// Steers each input message to one of p_noutputs channels by its top address
// bits, stripping them, with an independent FIFO per destination channel.
module buffered_router import router_pkg::*; #(
   parameter int p_nbits    = 32,
   parameter int p_noutputs = 8,
   parameter int p_depth    = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   valid,
   input  logic [p_nbits-1:0]                     message_in,
   output logic                                   ready_out,
   input  logic                                   ready [p_noutputs],
   output logic [p_noutputs-1:0]                  valid_out,
   output logic [p_nbits-addr_w(p_noutputs)-1:0]  message_out [p_noutputs],
   output logic [cnt_w(p_depth)-1:0]              occupancy [p_noutputs]
);

   localparam int AW = addr_w(p_noutputs);
   localparam int PL = p_nbits - AW;

   logic [AW-1:0]         sel;
   logic [PL-1:0]         payload;
   logic [p_noutputs-1:0] full;
   logic [p_noutputs-1:0] enq;

   assign sel     = message_in[p_nbits-1 -: AW];
   assign payload = message_in[PL-1:0];

   // Acceptance looks only at the addressed FIFO's current fill level, so no
   // downstream ready can reach ready_out combinationally.
   assign ready_out = !full[sel];

   always_comb begin
      enq      = '0;
      enq[sel] = valid && ready_out;
   end

   for (genvar g = 0; g < p_noutputs; g++) begin : g_chan
      router_fifo #(
         .p_nbits (PL),
         .p_depth (p_depth)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .enq_val (enq[g]),
         .enq_msg (payload),
         .full    (full[g]),
         .deq_rdy (ready[g]),
         .deq_val (valid_out[g]),
         .deq_msg (message_out[g]),
         .count   (occupancy[g])
      );
   end

endmodule

// File: tb/tb_buffered_router.sv
// Bench for buffered_router: directed literal checks plus random traffic
// compared every cycle against per-channel queue model.
module tb_buffered_router;

   localparam int NBITS = 32;
   localparam int NOUT  = 8;
   localparam int DEPTH = 2;
   localparam int PL    = 29;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid = 1'b0;
   logic [NBITS-1:0] message_in = '0;
   logic          ready_out;
   logic          ready [NOUT];
   logic [NOUT-1:0] valid_out;
   logic [PL-1:0] message_out [NOUT];
   logic [CW-1:0] occupancy [NOUT];

   int total = 0;
   int bad   = 0;

   logic [PL-1:0] mq [NOUT][$];

   buffered_router #(
      .p_nbits    (NBITS),
      .p_noutputs (NOUT),
      .p_depth    (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .valid       (valid),
      .message_in  (message_in),
      .ready_out   (ready_out),
      .ready       (ready),
      .valid_out   (valid_out),
      .message_out (message_out),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: one queue per channel, updated on each accepting/popping edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NOUT; i++) mq[i].delete();
      end else begin
         int  s;
         bit  acc;
         s   = int'(message_in[NBITS-1 -: 3]);
         acc = valid && (mq[s].size() < DEPTH);
         for (int i = 0; i < NOUT; i++)
            if (mq[i].size() > 0 && ready[i]) void'(mq[i].pop_front());
         if (acc) mq[s].push_back(message_in[PL-1:0]);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NOUT; i++) begin
         chk("model_valid_out", valid_out[i], (mq[i].size() > 0) ? 1 : 0);
         chk("model_occupancy", occupancy[i], mq[i].size());
         if (mq[i].size() > 0) chk("model_message_out", message_out[i], mq[i][0]);
      end
      chk("model_ready_out", ready_out,
          (mq[int'(message_in[NBITS-1 -: 3])].size() < DEPTH) ? 1 : 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic v);
      for (int i = 0; i < NOUT; i++) ready[i] = v;
   endtask

   initial begin
      bit hold;
      set_ready(1'b1);
      valid      = 1'b1;
      message_in = 32'hA0000005;
      #3;
      chk("rst_ready_out", ready_out, 1);
      chk("rst_valid_out", valid_out, 8'h00);
      for (int i = 0; i < NOUT; i++) chk("rst_occupancy", occupancy[i], 0);

      // Single message to channel 5
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("single_valid_out", valid_out, 8'h20);
      chk("single_msg5", message_out[5], 29'h0000005);
      step();
      @(negedge clk);
      chk("single_drained", valid_out, 8'h00);

      // Fill channel 3
      step();
      ready[3]   = 1'b0;
      valid      = 1'b1;
      message_in = 32'h60000001;
      step();
      message_in = 32'h60000002;
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("fill_occ3", occupancy[3], 2);
      message_in = 32'h60000003;
      #1;
      chk("fill_ready_addr3", ready_out, 0);
      message_in = 32'h00000000;
      #1;
      chk("fill_ready_addr0", ready_out, 1);

      // Head-of-line isolation while channel 3 is full and stalled
      step();
      valid      = 1'b1;
      message_in = 32'h00000007;
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("hol_valid0", valid_out[0], 1);
      chk("hol_msg0", message_out[0], 29'h7);
      chk("hol_occ3", occupancy[3], 2);

      // Release channel 3: in-order delivery
      step();
      ready[3] = 1'b1;
      @(negedge clk);
      chk("drain3_first", message_out[3], 29'h1);
      step();
      @(negedge clk);
      chk("drain3_second", message_out[3], 29'h2);
      step();
      @(negedge clk);
      chk("drain3_empty", valid_out[3], 0);

      // Simultaneous enqueue and dequeue on channel 2
      step();
      ready[2]   = 1'b0;
      valid      = 1'b1;
      message_in = 32'h40000011;
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("simul_occ_before", occupancy[2], 1);
      step();
      ready[2]   = 1'b1;
      valid      = 1'b1;
      message_in = 32'h40000012;
      #1;
      chk("simul_ready_out", ready_out, 1);
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("simul_occ_after", occupancy[2], 1);
      chk("simul_msg2", message_out[2], 29'h12);
      step();

      // Full channel 4 with pop and arrival in the same cycle
      ready[4]   = 1'b0;
      valid      = 1'b1;
      message_in = 32'h80000021;
      step();
      message_in = 32'h80000022;
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("fullpop_occ", occupancy[4], 2);
      step();
      ready[4]   = 1'b1;
      valid      = 1'b1;
      message_in = 32'h80000023;
      #1;
      chk("fullpop_ready_blocked", ready_out, 0);
      step();
      @(negedge clk);
      chk("fullpop_ready_next", ready_out, 1);
      chk("fullpop_occ_mid", occupancy[4], 1);
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("fullpop_occ_end", occupancy[4], 1);
      chk("fullpop_msg4", message_out[4], 29'h23);
      step();

      // Asynchronous reset with channels 1 and 6 occupied
      set_ready(1'b0);
      valid      = 1'b1;
      message_in = 32'h20000031;
      step();
      message_in = 32'hC0000032;
      step();
      valid = 1'b0;
      #2;
      chk("areset_pre_occ1", occupancy[1], 1);
      reset = 1'b0;
      #1;
      chk("areset_valid_out", valid_out, 8'h00);
      chk("areset_occ1", occupancy[1], 0);
      chk("areset_occ6", occupancy[6], 0);
      chk("areset_ready_out", ready_out, 1);
      step();
      reset      = 1'b1;
      ready[6]   = 1'b1;
      valid      = 1'b1;
      message_in = 32'hC0000033;
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("post_reset_valid6", valid_out, 8'h40);
      chk("post_reset_msg6", message_out[6], 29'h33);
      step();

      // Random traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         hold = valid && !ready_out;
         if (!hold) begin
            valid      = ($urandom_range(0, 3) != 0);
            message_in = $urandom;
         end
         for (int i = 0; i < NOUT; i++) ready[i] = ($urandom_range(0, 2) != 0);
         step();
      end
      valid = 1'b0;
      set_ready(1'b1);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/buffered_router.md
Name: buffered_router

Overview:
- Clocked successor to the combinational val/rdy packet router.
- Takes one input stream and steers each message to one of p_noutputs output channels using the top $clog2(p_noutputs) bits of the message, which are stripped before output.
- Each output channel has its own p_depth-entry FIFO, so a stalled destination does not block traffic already queued for other destinations.
- Sits between the packet source and per-destination consumers in the interconnect.

Parameters:
- p_nbits, 32, full input message width including the address field.
- p_noutputs, 8, number of output channels; power of two, >= 2.
- p_depth, 2, entries per output FIFO; >= 1, any integer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid  input  1  input message valid.
- message_in  input  p_nbits  [p_nbits-1 : p_nbits-AW] is the destination, AW=$clog2(p_noutputs); the low bits are the payload.
- ready_out  output  1  input ready; transfer occurs when valid && ready_out on a rising edge.
- ready  input  1 x p_noutputs (unpacked)  per-channel downstream ready; ready[i] belongs to channel i.
- valid_out  output  p_noutputs  per-channel valid; bit i belongs to channel i.
- message_out  output  (p_nbits-AW) x p_noutputs (unpacked)  per-channel payload, address stripped.
- occupancy  output  $clog2(p_depth+1) x p_noutputs (unpacked)  entries currently held per channel.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, occupancy 0, valid_out 0, ready_out 1.
- ready_out = !full[sel], where sel = message_in address field.
  - Combinational on message_in only; no combinational path from any ready[i].
  - ready_out may be 1 while valid is 0.
- Enqueue: when valid && ready_out, the payload is written to FIFO[sel]. Only one FIFO can enqueue per cycle.
- Latency: an accepted message appears on valid_out[sel]/message_out[sel] at the next rising edge. No same-cycle bypass.
- Dequeue: when valid_out[i] && ready[i], FIFO[i] pops. Any number of channels may pop in the same cycle.
- valid_out[i] = !empty[i].
- message_out[i] = head of FIFO[i]. It is don't-care when valid_out[i]=0; the bench must not check it then.
- Ordering: strict FIFO per channel. No ordering guarantee across channels.
- Full FIFO, simultaneous pop and new arrival: ready_out stays 0 that cycle (full is judged on the current state). The message is accepted on a later cycle.
- Not-full FIFO, enqueue and dequeue in the same cycle: occupancy unchanged, both operations take effect.
- Pointer wrap: read/write pointers wrap from p_depth-1 to 0; non-power-of-two p_depth is supported.
- Full/empty are derived from a per-channel count, 0..p_depth.
- valid && !ready_out: no state change. The source must hold message_in stable.
- Reset asserted mid-traffic: all queued messages are discarded immediately, and outputs go to their reset values without waiting for a clock edge.

Decomposition:
- Package router_pkg:
  - function addr_w(n) returning $clog2(n);
  - function cnt_w(depth) returning $clog2(depth+1).
- Sub-module router_fifo (p_nbits, p_depth):
  - ports: enq_val, enq_msg, full, deq_rdy, deq_val, deq_msg, count;
  - instantiated p_noutputs times in a generate loop.
- Top level holds only address decode, the per-channel enqueue-enable generation, and the ready_out mux.

Test Plan (p_nbits=32, p_noutputs=8, p_depth=2):
- Reset with valid=1 → ready_out=1, valid_out=8'h00, occupancy all 0. Deassert reset, then send 32'hA0000005 with ready[5]=1 → next cycle valid_out=8'h20, message_out[5]=29'h0000005; one cycle later valid_out=8'h00.
- Fill: ready[3]=0, send 32'h60000001, 32'h60000002 → occupancy[3]=2, ready_out=0 for any address-3 message, ready_out=1 for address 0. Raise ready[3] → 1, then 2 delivered in order.
- Head-of-line isolation: channel 3 full and stalled; send 32'h00000007 → valid_out[0]=1 next cycle, message_out[0]=29'h7.
- Simultaneous: occupancy[2]=1, ready[2]=1, send to address 2 → occupancy[2] stays 1; delivered data stays in order.
- Full + pop + arrival: occupancy[4]=2, ready[4]=1, valid to address 4 → ready_out=0 that cycle, accepted the next cycle.
- Async reset mid-traffic with several channels occupied → valid_out=0 and occupancy 0 before the next clock edge; the first post-reset message is delivered normally.
